// File: rtl/xps2_rx_if.sv
// Register bus between the controller and the PS/2 receiver, plus its interrupt line.
interface xps2_rx_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
);
   logic              sel;
   logic              rw_req;
   logic              rw_rnw;
   logic [ADDR_W-1:0] rw_addr;
   logic [DATA_W-1:0] data_to_wr;
   logic [DATA_W-1:0] data_to_rd;
   logic              irq;

   modport master (output sel, rw_req, rw_rnw, rw_addr, data_to_wr,
                   input  data_to_rd, irq);
   modport slave  (input  sel, rw_req, rw_rnw, rw_addr, data_to_wr,
                   output data_to_rd, irq);
endinterface

// File: rtl/xps2_rx.sv
// PS/2 keyboard receiver: deserialises device frames into a scancode FIFO that the
// program polls through DATA / STATUS / CTRL registers.
module xps2_rx #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   xps2_rx_if.slave   bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // ---------------- input conditioning
   logic [1:0] ck_s, dt_s;
   logic       ck_d, fall, bit_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         ck_s <= 2'b11;
         dt_s <= 2'b11;
         ck_d <= 1'b1;
      end else begin
         ck_s <= {ck_s[0], ps2_clk};
         dt_s <= {dt_s[0], ps2_data};
         ck_d <= ck_s[1];
      end
   end

   assign fall   = ck_d & ~ck_s[1];
   assign bit_in = dt_s[1];

   // ---------------- frame FSM
   state_t          st, st_nxt;
   logic [2:0]      bcnt;
   logic [7:0]      sr;
   logic            par_q;
   logic [TW-1:0]   to_cnt;
   logic            timed_out;
   logic            shift_en, par_en, eval_en, to_clr, bcnt_clr;
   logic            par_ok;
   logic            push_pend, perr_pend, ferr_pend;

   assign timed_out = (st != IDLE) && (to_cnt == TW'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst) st <= IDLE;
      else     st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      case (st)
         IDLE:    if (fall && !bit_in)        st_nxt = DATA;
         DATA:    if (fall && bcnt == 3'd7)   st_nxt = PARITY;
         PARITY:  if (fall)                   st_nxt = STOP;
         STOP:    if (fall)                   st_nxt = IDLE;
         default:                             st_nxt = IDLE;
      endcase
      // a fall in the same cycle as expiry still counts as progress
      if (!fall && timed_out) st_nxt = IDLE;
   end

   always_comb begin
      shift_en = fall && (st == DATA);
      par_en   = fall && (st == PARITY);
      eval_en  = fall && (st == STOP);
      to_clr   = fall || (st == IDLE);
      bcnt_clr = (st == IDLE);
   end

   // odd parity: data bits plus parity bit carry an odd number of ones
   assign par_ok = ^{sr, par_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt    <= '0;
         bcnt      <= '0;
         sr        <= '0;
         par_q     <= 1'b0;
         push_pend <= 1'b0;
         perr_pend <= 1'b0;
         ferr_pend <= 1'b0;
      end else begin
         if (to_clr)                        to_cnt <= '0;
         else if (to_cnt != TW'(TIMEOUT))   to_cnt <= to_cnt + 1'b1;
         if (bcnt_clr)      bcnt <= '0;
         else if (shift_en) bcnt <= bcnt + 3'd1;
         if (shift_en) sr    <= {bit_in, sr[7:1]};
         if (par_en)   par_q <= bit_in;
         push_pend <= eval_en & bit_in & par_ok;
         ferr_pend <= eval_en & ~bit_in;
         perr_pend <= eval_en & ~par_ok;
      end
   end

   // ---------------- FIFO and registers
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, cnt_nxt;
   logic          full, not_empty, rd_act, pop, push_ok, set_ovf, ctrl_wr, clr;
   logic          ovf, perr, ferr, irq_en, irq_q;
   logic [2:0]    occ;
   logic [7:0]    rd8;

   assign not_empty = (count != '0);
   assign full      = (count == CW'(FIFO_DEPTH));
   assign rd_act    = bus.sel & bus.rw_req & bus.rw_rnw;
   assign pop       = rd_act && (bus.rw_addr == ADDR_W'(0)) && not_empty;
   assign push_ok   = push_pend & (~full | pop);
   assign set_ovf   = push_pend & full & ~pop;
   assign ctrl_wr   = bus.sel && bus.rw_req && !bus.rw_rnw && (bus.rw_addr == ADDR_W'(2));
   assign clr       = ctrl_wr & bus.data_to_wr[1];
   assign cnt_nxt   = count + CW'(push_ok) - CW'(pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= sr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         perr   <= 1'b0;
         ferr   <= 1'b0;
         irq_en <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         count <= cnt_nxt;
         // sets take priority over a same-cycle clear
         ovf   <= set_ovf   | (ovf  & ~clr);
         perr  <= perr_pend | (perr & ~clr);
         ferr  <= ferr_pend | (ferr & ~clr);
         if (ctrl_wr) irq_en <= bus.data_to_wr[0];
         irq_q <= irq_en & (cnt_nxt != '0);
      end
   end

   assign occ = (int'(count) > 7) ? 3'd7 : 3'(count);

   always_comb begin
      rd8 = 8'h00;
      if (rd_act) begin
         case (bus.rw_addr)
            ADDR_W'(0): rd8 = not_empty ? mem[rd_ptr] : 8'h00;
            ADDR_W'(1): rd8 = {occ, ferr, perr, ovf, full, not_empty};
            ADDR_W'(2): rd8 = {7'b0, irq_en};
            default:    rd8 = 8'h00;
         endcase
      end
   end

   assign bus.data_to_rd = DATA_W'(rd8);
   assign bus.irq        = irq_q;

   logic unused_wr;
   assign unused_wr = ^bus.data_to_wr[DATA_W-1:2];
endmodule

// File: tb/tb_xps2_rx.sv
// Directed bench for xps2_rx: PS/2 frames are bit-banged at ~60 clk per half-period
// and the register map is checked against hand-computed values.
module tb_xps2_rx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   xps2_rx_if #(.DATA_W(8), .ADDR_W(2)) bus ();

   xps2_rx dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] code;
      bit         bad_par;
      bit         bad_stop;
      bit         do_read;
      logic [7:0] exp_status;
      logic [7:0] exp_rd;
      logic [7:0] exp_after;
   } vec_t;

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", nm, act, exp);
      end
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      bus.sel = 1'b1; bus.rw_req = 1'b1; bus.rw_rnw = 1'b1; bus.rw_addr = a;
      #1 d = bus.data_to_rd;
      @(negedge clk);
      bus.sel = 1'b0; bus.rw_req = 1'b0;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.sel = 1'b1; bus.rw_req = 1'b1; bus.rw_rnw = 1'b0; bus.rw_addr = a;
      bus.data_to_wr = d;
      @(negedge clk);
      bus.sel = 1'b0; bus.rw_req = 1'b0;
   endtask

   task automatic ps2_bit(input logic b);
      @(negedge clk);
      ps2_data = b;
      repeat (60) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (60) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   // start, 8 data bits LSB first, parity (odd unless bad_par)
   task automatic send_head(input logic [7:0] code, input bit bad_par);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(code[i]);
      ps2_bit(bad_par ? ^code : ~^code);
   endtask

   task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
      send_head(code, bad_par);
      ps2_bit(~bad_stop);
      @(negedge clk);
      ps2_data = 1'b1;
      repeat (60) @(negedge clk);
   endtask

   // Stop-bit fall at negedge N0 -> fall seen 2 edges later -> push pending in the
   // cycle after the third edge; the DATA read is placed in exactly that cycle.
   task automatic send_frame_rd(input logic [7:0] code, output logic [7:0] got);
      send_head(code, 1'b0);
      @(negedge clk);
      ps2_data = 1'b1;
      repeat (60) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      bus.sel = 1'b1; bus.rw_req = 1'b1; bus.rw_rnw = 1'b1; bus.rw_addr = 2'd0;
      #1 got = bus.data_to_rd;
      @(negedge clk);
      bus.sel = 1'b0; bus.rw_req = 1'b0;
      repeat (56) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (60) @(negedge clk);
   endtask

   vec_t vecs [8];
   logic [7:0] d;

   initial begin
      vecs[0] = '{8'h1C, 0, 0, 1, 8'h21, 8'h1C, 8'h00};
      vecs[1] = '{8'h1C, 1, 0, 0, 8'h08, 8'h00, 8'h08};
      vecs[2] = '{8'h1C, 0, 1, 0, 8'h18, 8'h00, 8'h18};
      vecs[3] = '{8'h01, 0, 0, 0, 8'h21, 8'h00, 8'h21};
      vecs[4] = '{8'h02, 0, 0, 0, 8'h41, 8'h00, 8'h41};
      vecs[5] = '{8'h03, 0, 0, 0, 8'h61, 8'h00, 8'h61};
      vecs[6] = '{8'h04, 0, 0, 0, 8'h83, 8'h00, 8'h83};
      vecs[7] = '{8'h05, 0, 0, 0, 8'h87, 8'h00, 8'h87};

      bus.sel = 1'b0; bus.rw_req = 1'b0; bus.rw_rnw = 1'b1;
      bus.rw_addr = 2'd0; bus.data_to_wr = 8'h00;

      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset data_to_rd idle", bus.data_to_rd, 8'h00);
      check("reset irq", {7'b0, bus.irq}, 8'h00);
      bus_rd(2'd1, d); check("reset STATUS", d, 8'h00);
      bus_rd(2'd2, d); check("reset CTRL", d, 8'h00);
      bus_rd(2'd0, d); check("empty DATA read", d, 8'h00);

      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            bus_wr(2'd2, 8'h02);
            bus_rd(2'd1, d); check("STATUS after clear", d, 8'h00);
         end
         send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop);
         bus_rd(2'd1, d); check($sformatf("vec%0d STATUS", i), d, vecs[i].exp_status);
         if (vecs[i].do_read) begin
            bus_rd(2'd0, d); check($sformatf("vec%0d DATA", i), d, vecs[i].exp_rd);
         end
         bus_rd(2'd1, d); check($sformatf("vec%0d STATUS after", i), d, vecs[i].exp_after);
      end

      for (int i = 1; i <= 5; i++) begin
         bus_rd(2'd0, d);
         check($sformatf("drain DATA %0d", i), d, (i == 5) ? 8'h00 : 8'(i));
      end
      bus_rd(2'd1, d); check("drained STATUS ovf", d, 8'h04);
      bus_wr(2'd2, 8'h02);
      bus_rd(2'd1, d); check("ovf cleared", d, 8'h00);

      // partial frame abandoned by timeout, then a good frame
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
      @(negedge clk); ps2_data = 1'b1;
      repeat (5100) @(negedge clk);
      send_frame(8'hF0, 0, 0);
      bus_rd(2'd1, d); check("timeout STATUS", d, 8'h21);
      bus_rd(2'd0, d); check("timeout DATA", d, 8'hF0);
      bus_rd(2'd1, d); check("timeout STATUS after", d, 8'h00);

      // simultaneous push and pop on a full FIFO
      for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 0, 0);
      bus_rd(2'd1, d); check("full STATUS", d, 8'h83);
      send_frame_rd(8'h14, d); check("push+pop DATA", d, 8'h10);
      bus_rd(2'd1, d); check("push+pop STATUS", d, 8'h83);
      for (int i = 1; i <= 4; i++) begin
         bus_rd(2'd0, d); check($sformatf("push+pop drain %0d", i), d, 8'h10 + 8'(i));
      end

      // irq timing
      bus_wr(2'd2, 8'h01);
      bus_rd(2'd2, d); check("CTRL irq_en", d, 8'h01);
      send_head(8'h5A, 0);
      @(negedge clk); ps2_data = 1'b1;
      repeat (60) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      check("irq low in push cycle", {7'b0, bus.irq}, 8'h00);
      @(negedge clk);
      check("irq high after push", {7'b0, bus.irq}, 8'h01);
      repeat (60) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (60) @(negedge clk);
      bus_rd(2'd0, d); check("irq frame DATA", d, 8'h5A);
      check("irq low after pop", {7'b0, bus.irq}, 8'h00);

      // reset mid-frame
      send_frame(8'h33, 0, 0);
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk); rst = 1'b0; ps2_data = 1'b1;
      repeat (200) @(negedge clk);
      bus_rd(2'd1, d); check("mid-frame reset STATUS", d, 8'h00);
      check("mid-frame reset irq", {7'b0, bus.irq}, 8'h00);
      bus_rd(2'd2, d); check("mid-frame reset CTRL", d, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
